// File: rtl/ber_pkg.sv
// rtl/ber_pkg.sv - shared types for the BER test sequencer
// Contents:
//   ber_status_e : 3-bit result code reported on ber_test_ctrl.status
//   ber_state_e  : sequencer FSM states
package ber_pkg;

    typedef enum logic [2:0] {
        IDLE_ST      = 3'd0,
        PASS         = 3'd1,
        FAIL         = 3'd2,
        LOCK_TIMEOUT = 3'd3,
        LOCK_LOST    = 3'd4,
        ABORTED      = 3'd5,
        BAD_CFG      = 3'd6,
        ERR_SAT      = 3'd7
    } ber_status_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_DONE      = 2'd3
    } ber_state_e;

endpackage

// File: rtl/ber_sat_accum.sv
// rtl/ber_sat_accum.sv - saturating accumulator with clear, add-enable and sticky saturated flag
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   clr             : zero the sum and the saturated flag (wins over en)
//   en, add         : add the zero-extended operand this cycle
//   sum, sat        : registered sum, sticky saturation flag
//   sum_peek        : value sum would take if add were accepted this cycle
//   ovf_peek        : accepting add this cycle would saturate
// IN_W must not exceed W.
module ber_sat_accum #(
    parameter int W    = 32,
    parameter int IN_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] add,
    output logic [W-1:0]    sum,
    output logic            sat,
    output logic [W-1:0]    sum_peek,
    output logic            ovf_peek
);

    logic [W:0] add_ext;
    logic [W:0] raw;

    assign add_ext  = {{(W + 1 - IN_W){1'b0}}, add};
    assign raw      = {1'b0, sum} + add_ext;
    // Carry out of the top bit means the true sum no longer fits: clamp.
    assign ovf_peek = raw[W];
    assign sum_peek = raw[W] ? {W{1'b1}} : raw[W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            sat <= 1'b0;
        end else if (en) begin
            sum <= sum_peek;
            sat <= sat | ovf_peek;
        end
    end

endmodule

// File: rtl/ber_test_ctrl.sv
// rtl/ber_test_ctrl.sv - sequencer for a PRBS generator/checker bit-error-rate test
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   start, abort             : begin a test (IDLE only) / terminate any test
//   cfg_words, cfg_lock_to   : words to measure, lock wait limit (sampled on accepted start)
//   chk_lock, err_num        : checker lock flag and per-word bit-error count
//   gen_en, chk_en           : generator/checker enables
//   busy, done, status       : activity, one-cycle completion pulse, result code
//   word_total, err_total    : measured words and accumulated bit errors
// Build option: BER_CTRL_RELOCK_EN - lock loss during RUN returns to WAIT_LOCK
// with totals kept instead of ending the test.
module ber_test_ctrl
    import ber_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32,
    parameter int TO_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_words,
    input  logic [TO_W-1:0]   cfg_lock_to,
    input  logic              chk_lock,
    input  logic [WIDTH:0]    err_num,
    output logic              gen_en,
    output logic              chk_en,
    output logic              busy,
    output logic              done,
    output ber_status_e       status,
    output logic [CNT_W-1:0]  word_total,
    output logic [CNT_W-1:0]  err_total
);

    ber_state_e        state, state_nxt;
    ber_status_e       status_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic [TO_W-1:0]   lock_to_q;
    logic [CNT_W-1:0]  words_q;
    logic [CNT_W-1:0]  word_nxt, word_inc;
    logic              cfg_load;
    logic              acc_clr, acc_en;
    logic              run_nxt;
    logic              err_sat, err_ovf;
    logic [CNT_W-1:0]  err_peek;

    ber_sat_accum #(
        .W    (CNT_W),
        .IN_W (WIDTH + 1)
    ) u_err_acc (
        .clk      (clk),
        .reset    (reset),
        .clr      (acc_clr),
        .en       (acc_en),
        .add      (err_num),
        .sum      (err_total),
        .sat      (err_sat),
        .sum_peek (err_peek),
        .ovf_peek (err_ovf)
    );

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        to_cnt_nxt = to_cnt;
        word_nxt   = word_total;
        word_inc   = word_total + CNT_W'(1);
        cfg_load   = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;

        if (abort) begin
            state_nxt  = ST_IDLE;
            status_nxt = ABORTED;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_load = 1'b1;
                        if (cfg_words == '0) begin
                            // Totals are left untouched so the previous result stays readable.
                            state_nxt  = ST_DONE;
                            status_nxt = BAD_CFG;
                        end else begin
                            state_nxt  = ST_WAIT_LOCK;
                            status_nxt = IDLE_ST;
                            to_cnt_nxt = '0;
                            word_nxt   = '0;
                            acc_clr    = 1'b1;
                        end
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is checked before the limit, so lock on the last allowed cycle still runs.
                    if (chk_lock) begin
                        state_nxt = ST_RUN;
                    end else if (to_cnt == lock_to_q) begin
                        state_nxt  = ST_DONE;
                        status_nxt = LOCK_TIMEOUT;
                    end else begin
                        to_cnt_nxt = to_cnt + TO_W'(1);
                    end
                end
                ST_RUN: begin
                    if (chk_lock) begin
                        acc_en   = 1'b1;
                        word_nxt = word_inc;
                        if (word_inc == words_q) begin
                            state_nxt = ST_DONE;
                            // Result must include this final word's errors.
                            if (err_sat || err_ovf) begin
                                status_nxt = ERR_SAT;
                            end else if (err_peek == '0) begin
                                status_nxt = PASS;
                            end else begin
                                status_nxt = FAIL;
                            end
                        end
                    end else begin
`ifdef BER_CTRL_RELOCK_EN
                        state_nxt  = ST_WAIT_LOCK;
                        to_cnt_nxt = '0;
`else
                        state_nxt  = ST_DONE;
                        status_nxt = LOCK_LOST;
`endif
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        run_nxt = (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            status     <= IDLE_ST;
            to_cnt     <= '0;
            word_total <= '0;
            words_q    <= '0;
            lock_to_q  <= '0;
            gen_en     <= 1'b0;
            chk_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            status     <= status_nxt;
            to_cnt     <= to_cnt_nxt;
            word_total <= word_nxt;
            if (cfg_load) begin
                words_q   <= cfg_words;
                lock_to_q <= cfg_lock_to;
            end
            // Outputs are registered from the next state so they line up with it.
            gen_en <= run_nxt;
            chk_en <= run_nxt;
            busy   <= run_nxt;
            done   <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_ber_test_ctrl.sv
// tb/tb_ber_test_ctrl.sv - scoreboard bench for ber_test_ctrl with randomized tests
module tb_ber_test_ctrl;
    import ber_pkg::*;

    localparam int CMAX = 511;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [8:0]  cfg_words;
    logic [7:0]  cfg_lock_to;
    logic        chk_lock;
    logic [8:0]  err_num;
    logic        gen_en, chk_en, busy, done;
    ber_status_e status;
    logic [8:0]  word_total, err_total;

    ber_test_ctrl #(.WIDTH(8), .CNT_W(9), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_words(cfg_words), .cfg_lock_to(cfg_lock_to),
        .chk_lock(chk_lock), .err_num(err_num),
        .gen_en(gen_en), .chk_en(chk_en), .busy(busy), .done(done),
        .status(status), .word_total(word_total), .err_total(err_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        ber_status_e st;
        int          words;
        int          errs;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mx;
    int          nvec = 0;
    int          nmis = 0;
    int          cyc  = 0;
    int          prev_w = 0;
    int          prev_e = 0;
    ber_status_e last_st = IDLE_ST;

    int          ew[0:255];
    bit          sl[0:2047];
    logic [8:0]  se[0:2047];
    int          slen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Any done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_done: got done=1 expected 0 (no test outstanding)");
            end else begin
                mx = sb.pop_front();
                chk("done_status", 32'(status), 32'(mx.st));
                chk("done_words", 32'(word_total), 32'(mx.words));
                chk("done_errs", 32'(err_total), 32'(mx.errs));
                chk("done_latency", 32'(cyc - mx.t0), 32'(mx.lat));
                chk("done_enables", {30'd0, gen_en, chk_en}, 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
            end
        end
    end

    function automatic int sum_err(input int cnt);
        int s = 0;
        for (int i = 0; i < cnt; i++) s += ew[i];
        return s;
    endfunction

    function automatic int clamp(input int s);
        return (s > CMAX) ? CMAX : s;
    endfunction

    // Outcome from the test parameters: lock after d idle cycles, n words,
    // optional lock drop before word k, relock after d2 further cycles.
    // lat counts clock edges from the accepting edge to the edge entering DONE.
    function automatic exp_t model(input int n, input int lto, input int d,
                                   input int k, input int d2);
        exp_t x;
        int   s;
        x.t0 = 0;
        if (n == 0) begin
            x.st = BAD_CFG; x.words = prev_w; x.errs = prev_e; x.lat = 0;
            return x;
        end
        if (d > lto) begin
            x.st = LOCK_TIMEOUT; x.words = 0; x.errs = 0; x.lat = lto + 1;
            return x;
        end
        x.lat = d + n + 1;
        if (k >= 0 && k < n) begin
`ifdef BER_CTRL_RELOCK_EN
            if (d2 > lto) begin
                x.st = LOCK_TIMEOUT; x.words = k; x.errs = clamp(sum_err(k));
                x.lat = d + k + lto + 3;
                return x;
            end
            x.lat = d + d2 + n + 3;
`else
            x.st = LOCK_LOST; x.words = k; x.errs = clamp(sum_err(k));
            x.lat = d + k + 2;
            return x;
`endif
        end
        s = sum_err(n);
        x.words = n;
        x.errs  = clamp(s);
        x.st    = (s > CMAX) ? ERR_SAT : ((s == 0) ? PASS : FAIL);
        return x;
    endfunction

    function automatic logic [8:0] rnd_err();
        return 9'($urandom_range(0, 8));
    endfunction

    task automatic put(input bit b, input logic [8:0] e);
        if (slen < 2048) begin
            sl[slen] = b;
            se[slen] = e;
            slen++;
        end
    endtask

    // Per-cycle lock/err stimulus starting at the first WAIT_LOCK cycle;
    // err_num carries noise whenever the word must not be counted.
    task automatic build(input int n, input int d, input int k, input int d2);
        slen = 0;
        for (int i = 0; i < d; i++) put(1'b0, rnd_err());
        put(1'b1, rnd_err());
        for (int i = 0; i < n; i++) begin
            if (i == k) begin
                put(1'b0, rnd_err());
`ifdef BER_CTRL_RELOCK_EN
                for (int j = 0; j < d2; j++) put(1'b0, rnd_err());
                put(1'b1, rnd_err());
`else
                break;
`endif
            end
            put(1'b1, 9'(ew[i]));
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL done_timeout: got no done pulse, expected %0d outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_test(input int n, input int lto, input int d, input int k,
                            input int d2, input bit inject);
        exp_t x;
        int   inj;
        if (n > 0) build(n, d, k, d2);
        x = model(n, lto, d, k, d2);
        @(negedge clk);
        start = 1'b1;
        cfg_words = 9'(n);
        cfg_lock_to = 8'(lto);
        x.t0 = cyc + 1;
        sb.push_back(x);
        if (n > 0) begin
            prev_w = x.words;
            prev_e = x.errs;
        end
        last_st = x.st;
        @(negedge clk);
        start = 1'b0;
        cfg_words = 9'($urandom);
        cfg_lock_to = 8'($urandom);
        if (n > 0) begin
            chk("enables_rise", {30'd0, gen_en, chk_en}, 32'd3);
            inj = inject ? int'($urandom_range(0, x.lat - 1)) : -1;
            for (int j = 0; j < slen && j <= x.lat; j++) begin
                chk_lock = sl[j];
                err_num  = se[j];
                start    = (j == inj);
                @(negedge clk);
            end
        end
        chk_lock = 1'b0;
        err_num  = '0;
        start    = 1'b0;
        wait_empty();
        @(negedge clk);
        chk("hold_busy", {30'd0, busy, gen_en}, 32'd0);
        chk("hold_words", 32'(word_total), 32'(prev_w));
        chk("hold_errs", 32'(err_total), 32'(prev_e));
        chk("hold_status", 32'(status), 32'(last_st));
    endtask

    task automatic fill_err(input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0: ew[i] = 0;
                1: ew[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : 0;
                default: ew[i] = int'($urandom_range(0, 8));
            endcase
        end
    endtask

    // Starts a test whose outcome is cut short (abort/reset); plays n_cyc stimulus cycles.
    task automatic start_partial(input int n, input int lto, input int d, input int n_cyc);
        build(n, d, -1, 0);
        @(negedge clk);
        start = 1'b1; cfg_words = 9'(n); cfg_lock_to = 8'(lto);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < n_cyc && j < slen; j++) begin
            chk_lock = sl[j];
            err_num  = se[j];
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, lto, d, k, d2;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_words = '0; cfg_lock_to = '0; chk_lock = 1'b0; err_num = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {28'd0, gen_en, chk_en, busy, done}, 32'd0);
        chk("rst_totals", {14'd0, word_total, err_total}, 32'd0);
        chk("rst_status", 32'(status), 32'(IDLE_ST));
        reset = 1'b1;

        // Clean 100-word run, then 3 single-bit errors.
        fill_err(0);
        run_test(100, 50, 4, -1, 0, 1'b0);
        for (int i = 10; i < 13; i++) ew[i] = 1;
        run_test(100, 50, 2, -1, 0, 1'b1);
        // Lock never arrives.
        run_test(30, 20, 200, -1, 0, 1'b0);
        // Lock drop after 40 words.
        fill_err(1);
        run_test(100, 50, 3, 40, 5, 1'b0);
        // Saturating error total.
        for (int i = 0; i < 256; i++) ew[i] = 8;
        run_test(80, 10, 0, -1, 0, 1'b0);
        // Zero-word config keeps previous totals.
        run_test(0, 5, 0, -1, 0, 1'b0);
        // Lock exactly at the limit still runs.
        fill_err(0);
        run_test(5, 7, 7, -1, 0, 1'b0);

        // Start and abort together: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; cfg_words = 9'd10; cfg_lock_to = 8'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_status", 32'(status), 32'(ABORTED));
        chk("abort_start_idle", {29'd0, busy, gen_en, chk_en}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_start_stays_idle", 32'(busy), 32'd0);

        // Abort mid-RUN: no done pulse (monitor would flag one).
        fill_err(1);
        start_partial(50, 10, 2, 13);
        abort = 1'b1; chk_lock = 1'b1;
        @(negedge clk);
        abort = 1'b0; chk_lock = 1'b0;
        chk("abort_run_status", 32'(status), 32'(ABORTED));
        chk("abort_run_idle", {29'd0, busy, gen_en, chk_en}, 32'd0);
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-RUN.
        start_partial(100, 5, 1, 30);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ctrl", {28'd0, gen_en, chk_en, busy, done}, 32'd0);
        chk("midrst_totals", {14'd0, word_total, err_total}, 32'd0);
        chk("midrst_status", 32'(status), 32'(IDLE_ST));
        chk_lock = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        prev_w = 0; prev_e = 0;
        run_test(0, 3, 0, -1, 0, 1'b0);

        // Randomized tests.
        for (int t = 0; t < 40; t++) begin
            n   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 100));
            lto = int'($urandom_range(0, 15));
            d   = ($urandom_range(0, 4) == 0) ? lto + 1 + int'($urandom_range(0, 5))
                                              : int'($urandom_range(0, lto));
            d2  = ($urandom_range(0, 4) == 0) ? lto + 1 + int'($urandom_range(0, 5))
                                              : int'($urandom_range(0, lto));
            k   = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            fill_err(int'($urandom_range(0, 2)));
            run_test(n, lto, d, k, d2, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
